// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the multi-port architectural register file.
// Optional feature macro used by this slice: REG_FILE_BYPASS_EN (same-cycle write forwarding).
package reg_file_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int REG_DATA_W_DEFAULT = 32;

    typedef logic [REG_ADDR_W_DEFAULT-1:0] arch_reg_id_t;
    typedef logic [REG_DATA_W_DEFAULT-1:0] arch_reg_t;

    // One writeback port at default widths, as seen by writeback stages.
    typedef struct packed {
        arch_reg_id_t addr;
        arch_reg_t    data;
        logic         en;
    } reg_file_wr_port_t;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Busy scoreboard for the register file: set on allocate, cleared on writeback,
// allocate wins over a same-cycle writeback. Register 0 is never busy.
// With REG_FILE_BYPASS_EN defined, a read port whose register is being written this
// cycle sees busy as the post-edge value (0, unless it is also being allocated).
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [(2**ADDR_W)-1:0]   busy_out
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] set_vec;

    // Decode writebacks (clear) and allocation (set); allocation has priority.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                clr_vec[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (alloc_en && (alloc_addr != '0)) begin
            set_vec[alloc_addr] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    // Busy vector register, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port busy lookup, optionally reflecting this cycle's writeback.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
`ifdef REG_FILE_BYPASS_EN
            if (reset) begin
                rd_busy[i] = 1'b0;
            end else if (clr_vec[rd_addr[i*ADDR_W +: ADDR_W]]) begin
                rd_busy[i] = set_vec[rd_addr[i*ADDR_W +: ADDR_W]];
            end else begin
                rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
            end
`else
            rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
`endif
        end
    end

    assign busy_out = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port architectural register file with busy scoreboard. Reads are
// combinational, writes land on the rising edge, highest write port wins on a
// collision, register 0 reads zero. Optional macro REG_FILE_BYPASS_EN forwards
// same-cycle write data to matching read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int              DATA_W   = REG_DATA_W_DEFAULT,
    parameter int              ADDR_W   = REG_ADDR_W_DEFAULT,
    parameter int              NUM_RD   = 2,
    parameter int              NUM_WR   = 1,
    parameter int              SP_INDEX = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h03FF_FFFC
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_RD*ADDR_W-1:0]        rd_addr,
    output logic [NUM_RD*DATA_W-1:0]        rd_data,
    output logic [NUM_RD-1:0]               rd_busy,
    input  logic [NUM_WR-1:0]               wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]        wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]        wr_data,
    input  logic                            alloc_en,
    input  logic [ADDR_W-1:0]               alloc_addr,
    output logic [(2**ADDR_W)-1:0]          busy_out,
    output logic [(2**ADDR_W)*DATA_W-1:0]   registers_out
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Apply writes in port order so the highest-index port wins; register 0 stays zero.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
            end
        end
        regs_d[0] = '0;
    end

    // Register array; reset clears everything except the stack pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= ((r == SP_INDEX) && (r != 0)) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports, optionally forwarding this cycle's write data.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (!reset && wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0) &&
                    (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                end
            end
`endif
        end
    end

    // Flattened trace view of the array.
    for (genvar r = 0; r < DEPTH; r++) begin : g_trace
        assign registers_out[r*DATA_W +: DATA_W] = regs_q[r];
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .busy_out   (busy_out)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp at NUM_RD=4, NUM_WR=2, DATA_W=64: directed vectors with
// literal expectations plus a random phase, all checked every cycle against an
// array model of the register file and scoreboard.
module tb_reg_file_mp;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int NW    = 2;
    localparam int DEPTH = 32;
    localparam logic [DW-1:0] SP = 64'h0000_0000_03FF_FFFC;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NR*AW-1:0]      rd_addr = '0;
    logic [NR*DW-1:0]      rd_data;
    logic [NR-1:0]         rd_busy;
    logic [NW-1:0]         wr_en = '0;
    logic [NW*AW-1:0]      wr_addr = '0;
    logic [NW*DW-1:0]      wr_data = '0;
    logic                  alloc_en = 1'b0;
    logic [AW-1:0]         alloc_addr = '0;
    logic [DEPTH-1:0]      busy_out;
    logic [DEPTH*DW-1:0]   registers_out;

    int checks = 0;
    int errors = 0;

    // Model state: plain arrays of architectural values and busy flags.
    logic [DW-1:0]    m_regs [DEPTH];
    logic [DEPTH-1:0] m_busy;
    logic [DEPTH*DW-1:0] exp_rst_vec;

    reg_file_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .NUM_WR   (NW),
        .SP_INDEX (2),
        .SP_RESET (SP)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_busy       (rd_busy),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .alloc_en      (alloc_en),
        .alloc_addr    (alloc_addr),
        .busy_out      (busy_out),
        .registers_out (registers_out)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: after an edge each written register holds the last port's data,
    // busy = (busy & not written) | allocated; register 0 untouched.
    always @(posedge clk or posedge reset) begin : model_upd
        logic [DW-1:0]    nr [DEPTH];
        logic [DEPTH-1:0] wrote;
        logic [DEPTH-1:0] alloc_m;
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) m_regs[r] <= (r == 2) ? SP : '0;
            m_busy <= '0;
        end else begin
            nr      = m_regs;
            wrote   = '0;
            alloc_m = '0;
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
                    nr[wr_addr[j*AW +: AW]]    = wr_data[j*DW +: DW];
                    wrote[wr_addr[j*AW +: AW]] = 1'b1;
                end
            end
            if (alloc_en && alloc_addr != 0) alloc_m[alloc_addr] = 1'b1;
            m_regs <= nr;
            m_busy <= (m_busy & ~wrote) | alloc_m;
        end
    end

    function automatic logic [DW-1:0] exp_data(input int i);
        logic [AW-1:0] ra;
        logic [DW-1:0] e;
        ra = rd_addr[i*AW +: AW];
        e  = (ra == 0) ? '0 : m_regs[ra];
`ifdef REG_FILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (!reset && wr_en[j] && wr_addr[j*AW +: AW] != 0 && wr_addr[j*AW +: AW] == ra)
                e = wr_data[j*DW +: DW];
`endif
        return e;
    endfunction

    function automatic logic exp_busy(input int i);
        logic [AW-1:0] ra;
        logic b;
        ra = rd_addr[i*AW +: AW];
        b  = (ra == 0) ? 1'b0 : m_busy[ra];
`ifdef REG_FILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (!reset && wr_en[j] && wr_addr[j*AW +: AW] != 0 && wr_addr[j*AW +: AW] == ra)
                b = alloc_en && (alloc_addr == ra);
`endif
        return b;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("model_rd_data%0d", i), rd_data[i*DW +: DW], exp_data(i));
                chk($sformatf("model_rd_busy%0d", i), {63'd0, rd_busy[i]}, {63'd0, exp_busy(i)});
            end
            chk("model_busy_out", {32'd0, busy_out}, {32'd0, m_busy});
        end
    end

    // Driver helpers.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en    = '0;
        alloc_en = 1'b0;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[j*AW +: AW] = a;
        wr_data[j*DW +: DW] = d;
        wr_en[j]            = 1'b1;
    endtask

    task automatic do_alloc(input logic [AW-1:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
        return a;
    endfunction

    initial begin
        exp_rst_vec = '0;
        exp_rst_vec[2*DW +: DW] = SP;

        // Reset from power-up.
        #2 reset = 1'b1;
        #1;
        set_rd(0, 2); set_rd(1, 5); set_rd(2, 0); set_rd(3, 31);
        #1;
        chk("rst_sp", rd_data[0 +: DW], SP);
        chk("rst_r5", rd_data[DW +: DW], '0);
        chk("rst_busy_out", {32'd0, busy_out}, '0);
        chk("rst_regs_out", {63'd0, registers_out === exp_rst_vec}, 64'd1);
        cyc(); cyc();
        reset = 1'b0;

        // Basic write to 5, read in the same cycle and the next.
        set_rd(0, 5);
        set_wr(0, 5, 64'hDEADBEEF);
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("wr5_same", rd_data[0 +: DW], 64'hDEADBEEF);
`else
        chk("wr5_same", rd_data[0 +: DW], 64'd0);
`endif
        cyc(); clear_inputs(); #1;
        chk("wr5_next", rd_data[0 +: DW], 64'hDEADBEEF);

        // Write and allocate on register 0 are discarded.
        set_rd(1, 0);
        set_wr(0, 0, 64'h1234);
        do_alloc(0);
        cyc(); clear_inputs(); #1;
        chk("zero_rd", rd_data[DW +: DW], 64'd0);
        chk("zero_busy", {32'd0, busy_out}, 64'd0);
        cyc();
        chk("zero_rd2", rd_data[DW +: DW], 64'd0);

        // Two write ports hit register 7; port 1 wins, busy clears.
        do_alloc(7);
        cyc(); clear_inputs(); #1;
        set_rd(2, 7);
        #1;
        chk("busy7_set", {63'd0, rd_busy[2]}, 64'd1);
        set_wr(0, 7, 64'hAAAA);
        set_wr(1, 7, 64'h5555);
        cyc(); clear_inputs(); #1;
        chk("conf_data", rd_data[2*DW +: DW], 64'h5555);
        chk("conf_busy", {63'd0, busy_out[7]}, 64'd0);

        // Scoreboard on register 9: set, allocate beats writeback, then clear.
        do_alloc(9);
        cyc(); clear_inputs(); #1;
        set_rd(3, 9);
        #1;
        chk("busy9_set", {63'd0, rd_busy[3]}, 64'd1);
        set_wr(0, 9, 64'h99);
        do_alloc(9);
        cyc(); clear_inputs(); #1;
        chk("busy9_alloc_wins", {63'd0, rd_busy[3]}, 64'd1);
        chk("data9_written", rd_data[3*DW +: DW], 64'h99);
        set_wr(0, 9, 64'h77);
        cyc(); clear_inputs(); #1;
        chk("busy9_clear", {63'd0, rd_busy[3]}, 64'd0);
        chk("data9_second", rd_data[3*DW +: DW], 64'h77);

        // Read during write on busy register 3.
        do_alloc(3);
        cyc(); clear_inputs(); #1;
        set_rd(0, 3);
        set_wr(1, 3, 64'hCAFEF00D);
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("byp_data", rd_data[0 +: DW], 64'hCAFEF00D);
        chk("byp_busy", {63'd0, rd_busy[0]}, 64'd0);
`else
        chk("byp_data", rd_data[0 +: DW], 64'd0);
        chk("byp_busy", {63'd0, rd_busy[0]}, 64'd1);
`endif
        cyc(); clear_inputs(); #1;
        chk("byp_next_data", rd_data[0 +: DW], 64'hCAFEF00D);
        chk("byp_next_busy", {63'd0, rd_busy[0]}, 64'd0);

        // Asynchronous reset mid-cycle with a write and allocation pending.
        set_rd(0, 2); set_rd(1, 11);
        set_wr(0, 11, 64'hBAD);
        do_alloc(12);
        #1 reset = 1'b1;
        #1;
        chk("mrst_sp", rd_data[0 +: DW], SP);
        chk("mrst_r11", rd_data[DW +: DW], 64'd0);
        chk("mrst_busy_out", {32'd0, busy_out}, 64'd0);
        chk("mrst_rd_busy", {60'd0, rd_busy}, 64'd0);
        cyc();
        chk("mrst_nowr", rd_data[DW +: DW], 64'd0);
        clear_inputs();
        cyc();
        reset = 1'b0;
        cyc();
        chk("mrst_after_r11", rd_data[DW +: DW], 64'd0);
        chk("mrst_after_regs", {63'd0, registers_out === exp_rst_vec}, 64'd1);

        // Random traffic, checked by the model every cycle.
        repeat (10000) begin
            for (int i = 0; i < NR; i++) set_rd(i, rnd_addr());
            wr_en = '0;
            for (int j = 0; j < NW; j++) begin
                wr_addr[j*AW +: AW] = rnd_addr();
                wr_data[j*DW +: DW] = {$urandom, $urandom};
                wr_en[j]            = 1'($urandom_range(0, 1));
            end
            alloc_en   = 1'($urandom_range(0, 1));
            alloc_addr = rnd_addr();
            cyc();
        end
        clear_inputs();
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
